bayer_stream_gen: RTL and testbench
===================================

// Module: bayer_stream_gen
// PURPOSE
// - Synthesisable transmitter for the raw Bayer pixel-stream interface (frame_valid / line_valid / 10b data) that the camera pipeline consumes.
// - Drives the crop -> debayer -> metering -> JPEG chain in place of the CSI-2/byte-to-pixel path for bring-up, self-test and regression.
// - Emits one frame per start, or frames back-to-back, with programmable size, blanking and test pattern. Phase is RGGB; (0,0) is a red site.
// PARAMETERS
// - MAX_X_SIZE   1288  largest x_size_in accepted; larger values are clamped to it
// - MAX_Y_SIZE   768   largest y_size_in accepted; larger values are clamped to it
// PORTS
// - pixel_clock_in       in   1   pixel clock (36MHz); the only clock
// - pixel_reset_n_in     in   1   synchronous, active-low reset
// - start_in             in   1   request one frame; sampled only in IDLE
// - continuous_in        in   1   1 = restart automatically at end of frame
// - pattern_select_in    in   2   0 flat, 1 ramp, 2 checker, 3 frame-counter
// - x_size_in            in   11  pixels per line
// - y_size_in            in   11  lines per frame
// - h_blank_in           in   8   blank cycles after each line (0 treated as 1)
// - v_blank_in           in   8   frame_valid-high porch before the first / after the last line (0 treated as 1)
// - bayer_data_out       out  10  pixel data; 0 whenever line_valid_out = 0
// - line_valid_out       out  1   high for exactly x_size cycles per line
// - frame_valid_out      out  1   high from front porch through back porch
// - busy_out             out  1   high in any state other than IDLE
// - frame_count_out      out  8   completed frames, wraps 255 -> 0
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0.
// - Reset asserted mid-frame: all outputs are 0 after the next edge. No partial-line completion.
// - All outputs are registered.
// - FSM states: IDLE, V_FRONT, LINE, H_BLANK, V_BACK, GAP.
// - IDLE -> V_FRONT when start_in = 1 and x_size_in != 0 and y_size_in != 0.
//   - On this transition, size, blanking and pattern inputs are latched.
//   - frame_valid_out rises on the same edge.
//   - Start with a zero size is ignored.
// - V_FRONT: lasts max(v_blank,1) cycles, then LINE.
// - LINE: line_valid_out = 1 for exactly x_size cycles, pixel x = 0..x_size-1, then H_BLANK.
// - H_BLANK: lasts max(h_blank,1) cycles.
//   - If lines remain, go to LINE.
//   - After the last line, go to V_BACK.
// - V_BACK: lasts max(v_blank,1) cycles.
//   - On exit, frame_valid_out falls and frame_count_out increments on the same edge.
//   - Next state is GAP.
// - GAP: exactly 1 cycle with frame_valid_out = 0.
//   - If continuous_in = 1, go to V_FRONT and re-latch the configuration inputs.
//   - Otherwise go to IDLE.
// - Latency:
//   - Sampling edge of start_in -> frame_valid_out high: 1 cycle.
//   - Sampling edge of start_in -> first line_valid_out high: 1 + max(v_blank,1) cycles.
//   - Frame length (frame_valid_out high) = 2*max(v_blank,1) + y*(x + max(h_blank,1)) cycles.
// - start_in while busy is ignored; there is no queueing.
// - Input changes mid-frame have no effect until the next latch.
// - Pattern value at (x,y), 10b unsigned:
//   - 0 flat:
//     - R site (y even, x even) = 10'h3FF
//     - G sites = 10'h200
//     - B site (y odd, x odd) = 10'h000
//   - 1 ramp: x[9:0]; the upper x bit is dropped, so the ramp wraps at 1024.
//   - 2 checker: (x[3] ^ y[3]) ? 10'h3FF : 10'h000
//   - 3 frame-counter: {frame_count[7:0], x[1:0]}
// - Counters: x and y are 11-bit, compared against the latched size minus 1. There is no counter overflow because sizes are clamped to MAX_X_SIZE / MAX_Y_SIZE.
// STRUCTURE
// - bayer_stream_pkg:
//   - typedef enum logic [1:0] pattern_e {PAT_FLAT, PAT_RAMP, PAT_CHECKER, PAT_COUNT}
//   - typedef enum state_e for the FSM
//   - localparams for flat R/G/B values
// - Sub-module bayer_pattern_pixel: combinational (pattern, x, y, frame_count) -> 10b value. Registered in the parent.
// - Parent contains the FSM, x/y/blank counters, configuration latch and output registers.
// TESTING
// - Reset plus a single start with x=4, y=2, h=2, v=3, pattern 0:
//   - frame_valid_out high for 2*3 + 2*(4+2) = 18 cycles.
//   - Line 0 data = 3FF,200,3FF,200; line 1 data = 200,000,200,000.
//   - frame_count_out = 1 after the frame.
// - Zero blanking, x=3, y=3 (h=0, v=0):
//   - Exactly 1 blank cycle between lines and 1 porch cycle at each end.
//   - frame_valid_out high for 14 cycles.
// - Continuous mode with x=8, y=1, pattern 3:
//   - Frames repeat with exactly one frame_valid_out-low cycle between them.
//   - Frame n carries data {n, 2'bxx}.
//   - frame_count_out wraps 255 -> 0 after 256 frames.
// - Start pulsed mid-frame and x_size_in changed mid-frame:
//   - The current frame is unaffected and no second frame is queued.
//   - Start with y_size_in = 0 leaves busy_out = 0.
// - Reset asserted during LINE of a 16x16 frame:
//   - All outputs are 0 on the next edge.
//   - After release, a new start produces a complete, correct frame.
// - Pattern 1 with x = 1100, and pattern 2 with x=y=16:
//   - Pattern 1: data wraps 1023 -> 0 at x = 1024.
//   - Pattern 2: checker toggles every 8 pixels and every 8 lines.

Source files
------------

// File: rtl/bayer_stream_gen_pkg.sv
`default_nettype none
// ==== bayer_stream_pkg : shared types and constants for the Bayer stream generator (Rev 1.0) ====
package bayer_stream_pkg;

  typedef enum logic [1:0] {
    PAT_FLAT    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_COUNT   = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_V_FRONT = 3'd1,
    ST_LINE    = 3'd2,
    ST_H_BLANK = 3'd3,
    ST_V_BACK  = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  localparam logic [9:0] c_FLAT_R   = 10'h3FF;
  localparam logic [9:0] c_FLAT_G   = 10'h200;
  localparam logic [9:0] c_FLAT_B   = 10'h000;
  localparam logic [9:0] c_CHECK_HI = 10'h3FF;
  localparam logic [9:0] c_CHECK_LO = 10'h000;

endpackage
`default_nettype wire

// File: rtl/bayer_stream_gen_if.sv
`default_nettype none
// ==== bayer_stream_gen_if : configuration inputs and raw Bayer stream outputs (Rev 1.0) ====
interface bayer_stream_gen_if;
  logic        start_in;
  logic        continuous_in;
  logic [1:0]  pattern_select_in;
  logic [10:0] x_size_in;
  logic [10:0] y_size_in;
  logic [7:0]  h_blank_in;
  logic [7:0]  v_blank_in;
  logic [9:0]  bayer_data_out;
  logic        line_valid_out;
  logic        frame_valid_out;
  logic        busy_out;
  logic [7:0]  frame_count_out;

  modport master (
    input  start_in, continuous_in, pattern_select_in,
    input  x_size_in, y_size_in, h_blank_in, v_blank_in,
    output bayer_data_out, line_valid_out, frame_valid_out, busy_out, frame_count_out
  );

  modport slave (
    output start_in, continuous_in, pattern_select_in,
    output x_size_in, y_size_in, h_blank_in, v_blank_in,
    input  bayer_data_out, line_valid_out, frame_valid_out, busy_out, frame_count_out
  );
endinterface
`default_nettype wire

// File: rtl/bayer_stream_gen_pixel.sv
`default_nettype none
// ==== bayer_pattern_pixel : combinational test-pattern value for one pixel site (Rev 1.0) ====
module bayer_pattern_pixel
  import bayer_stream_pkg::*;
(
  input  wire pattern_e   i_pattern,
  input  wire logic [9:0] i_x,
  input  wire logic       i_y_odd,
  input  wire logic       i_y_bit3,
  input  wire logic [7:0] i_frame_count,
  output logic [9:0]      o_pixel
);

  always_comb begin
    o_pixel = '0;
    case (i_pattern)
      // RGGB phase: even row/even column is red, odd row/odd column is blue
      PAT_FLAT: begin
        if (!i_y_odd && !i_x[0])     o_pixel = c_FLAT_R;
        else if (i_y_odd && i_x[0])  o_pixel = c_FLAT_B;
        else                         o_pixel = c_FLAT_G;
      end
      PAT_RAMP:    o_pixel = i_x;
      PAT_CHECKER: o_pixel = (i_x[3] ^ i_y_bit3) ? c_CHECK_HI : c_CHECK_LO;
      PAT_COUNT:   o_pixel = {i_frame_count, i_x[1:0]};
      default:     o_pixel = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bayer_stream_gen.sv
`default_nettype none
// ==== bayer_stream_gen : raw Bayer frame/line/data stream transmitter for bring-up and self-test (Rev 1.0) ====
module bayer_stream_gen
  import bayer_stream_pkg::*;
#(
  parameter int MAX_X_SIZE = 1288,
  parameter int MAX_Y_SIZE = 768
) (
  input  wire logic          pixel_clock_in,
  input  wire logic          pixel_reset_n_in,
  bayer_stream_gen_if.master bus
);

  localparam logic [10:0] c_MAX_X = 11'(MAX_X_SIZE);
  localparam logic [10:0] c_MAX_Y = 11'(MAX_Y_SIZE);

  state_e      r_state, w_state_nxt;
  logic [10:0] r_cnt, w_cnt_nxt;
  logic [10:0] r_y, w_y_nxt;
  logic [10:0] r_x_last, r_y_last;
  logic [7:0]  r_h_last, r_v_last;
  pattern_e    r_pat;
  logic [7:0]  r_fc;
  logic [9:0]  r_data;
  logic        r_lv, r_fv, r_busy;

  logic        w_latch, w_fc_inc, w_cfg_ok;
  logic [10:0] w_x_clamp, w_y_clamp;
  logic [7:0]  w_h_eff, w_v_eff;
  logic [9:0]  w_pixel;

  assign w_x_clamp = (bus.x_size_in > c_MAX_X) ? c_MAX_X : bus.x_size_in;
  assign w_y_clamp = (bus.y_size_in > c_MAX_Y) ? c_MAX_Y : bus.y_size_in;
  assign w_h_eff   = (bus.h_blank_in == 8'd0) ? 8'd1 : bus.h_blank_in;
  assign w_v_eff   = (bus.v_blank_in == 8'd0) ? 8'd1 : bus.v_blank_in;
  assign w_cfg_ok  = (bus.x_size_in != 11'd0) && (bus.y_size_in != 11'd0);

  // r_cnt is the pixel index in LINE and the elapsed-cycle count in every blanking state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 11'd1;
    w_y_nxt     = r_y;
    w_latch     = 1'b0;
    w_fc_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.start_in && w_cfg_ok) begin
          w_state_nxt = ST_V_FRONT;
          w_latch     = 1'b1;
        end
      end
      ST_V_FRONT: begin
        if (r_cnt == {3'b000, r_v_last}) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = '0;
          w_y_nxt     = '0;
        end
      end
      ST_LINE: begin
        if (r_cnt == r_x_last) begin
          w_state_nxt = ST_H_BLANK;
          w_cnt_nxt   = '0;
        end
      end
      ST_H_BLANK: begin
        if (r_cnt == {3'b000, r_h_last}) begin
          w_cnt_nxt = '0;
          if (r_y == r_y_last) begin
            w_state_nxt = ST_V_BACK;
          end else begin
            w_state_nxt = ST_LINE;
            w_y_nxt     = r_y + 11'd1;
          end
        end
      end
      ST_V_BACK: begin
        if (r_cnt == {3'b000, r_v_last}) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
          w_fc_inc    = 1'b1;
        end
      end
      ST_GAP: begin
        w_cnt_nxt = '0;
        if (bus.continuous_in && w_cfg_ok) begin
          w_state_nxt = ST_V_FRONT;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  bayer_pattern_pixel u_pixel (
    .i_pattern     (r_pat),
    .i_x           (w_cnt_nxt[9:0]),
    .i_y_odd       (w_y_nxt[0]),
    .i_y_bit3      (w_y_nxt[3]),
    .i_frame_count (r_fc),
    .o_pixel       (w_pixel)
  );

  always_ff @(posedge pixel_clock_in) begin
    if (!pixel_reset_n_in) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_y      <= '0;
      r_x_last <= '0;
      r_y_last <= '0;
      r_h_last <= '0;
      r_v_last <= '0;
      r_pat    <= PAT_FLAT;
      r_fc     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      if (w_latch) begin
        r_x_last <= w_x_clamp - 11'd1;
        r_y_last <= w_y_clamp - 11'd1;
        r_h_last <= w_h_eff - 8'd1;
        r_v_last <= w_v_eff - 8'd1;
        r_pat    <= pattern_e'(bus.pattern_select_in);
      end
      if (w_fc_inc) r_fc <= r_fc + 8'd1;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM
  always_ff @(posedge pixel_clock_in) begin
    if (!pixel_reset_n_in) begin
      r_data <= '0;
      r_lv   <= 1'b0;
      r_fv   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_data <= (w_state_nxt == ST_LINE) ? w_pixel : 10'd0;
      r_lv   <= (w_state_nxt == ST_LINE);
      r_fv   <= (w_state_nxt inside {ST_V_FRONT, ST_LINE, ST_H_BLANK, ST_V_BACK});
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.bayer_data_out  = r_data;
  assign bus.line_valid_out  = r_lv;
  assign bus.frame_valid_out = r_fv;
  assign bus.busy_out        = r_busy;
  assign bus.frame_count_out = r_fc;

endmodule
`default_nettype wire

// File: tb/tb_bayer_stream_gen.sv
`default_nettype none
// ==== tb_bayer_stream_gen : self-checking bench for bayer_stream_gen (Rev 1.0) ====
module tb_bayer_stream_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bayer_stream_gen_if bus ();

  bayer_stream_gen #(.MAX_X_SIZE(1288), .MAX_Y_SIZE(768)) dut (
    .pixel_clock_in   (clk),
    .pixel_reset_n_in (rst_n),
    .bus              (bus)
  );

  typedef struct {
    int    x;
    int    y;
    int    h;
    int    v;
    int    pat;
    int    exp_len;
    string name;
  } vec_t;

  vec_t        vecs [7];
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          model_fc = 0;
  logic [20:0] exp_q [$];

  // {busy, frame_valid, line_valid, data[9:0], frame_count[7:0]}
  function automatic logic [20:0] pack(bit busy, bit fv, bit lv, logic [9:0] d, int fc);
    return {busy, fv, lv, d, 8'(fc)};
  endfunction

  function automatic logic [20:0] observed();
    return {bus.busy_out, bus.frame_valid_out, bus.line_valid_out,
            bus.bayer_data_out, bus.frame_count_out};
  endfunction

  function automatic logic [9:0] ref_pix(int pat, int x, int y, int fc);
    case (pat)
      0: begin
        if ((y % 2 == 0) && (x % 2 == 0))      return 10'h3FF;
        else if ((y % 2 == 1) && (x % 2 == 1)) return 10'h000;
        else                                   return 10'h200;
      end
      1:       return 10'(x % 1024);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
      default: return 10'(((fc % 256) * 4) + (x % 4));
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycle-by-cycle trace of one frame plus its trailing one-cycle gap
  task automatic build_frame(input int x, input int y, input int h, input int v,
                             input int pat, input int fc);
    int xe, ye, he, ve;
    xe = (x > 1288) ? 1288 : x;
    ye = (y > 768) ? 768 : y;
    he = (h == 0) ? 1 : h;
    ve = (v == 0) ? 1 : v;
    repeat (ve) exp_q.push_back(pack(1, 1, 0, 0, fc));
    for (int yy = 0; yy < ye; yy++) begin
      for (int xx = 0; xx < xe; xx++) exp_q.push_back(pack(1, 1, 1, ref_pix(pat, xx, yy, fc), fc));
      repeat (he) exp_q.push_back(pack(1, 1, 0, 0, fc));
    end
    repeat (ve) exp_q.push_back(pack(1, 1, 0, 0, fc));
    exp_q.push_back(pack(1, 0, 0, 0, (fc + 1) % 256));
  endtask

  task automatic run_frames(input int x, input int y, input int h, input int v, input int pat,
                            input int nframes, input int disturb_at, input string name,
                            output int fv_len);
    int          cyc;
    logic [20:0] e;
    bus.x_size_in         = 11'(x);
    bus.y_size_in         = 11'(y);
    bus.h_blank_in        = 8'(h);
    bus.v_blank_in        = 8'(v);
    bus.pattern_select_in = 2'(pat);
    bus.continuous_in     = (nframes > 1);
    bus.start_in          = 1'b1;
    tick();
    bus.start_in = 1'b0;
    fv_len = 0;
    for (int f = 0; f < nframes; f++) begin
      build_frame(x, y, h, v, pat, model_fc);
      if (f == nframes - 1) bus.continuous_in = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(name, 32'(observed()), 32'(e));
        if (f == 0 && bus.frame_valid_out === 1'b1) fv_len++;
        if (f == 0 && cyc == disturb_at) begin
          bus.start_in  = 1'b1;
          bus.x_size_in = 11'(x + 3);
        end else begin
          bus.start_in  = 1'b0;
          bus.x_size_in = 11'(x);
        end
        cyc++;
        tick();
      end
      model_fc = (model_fc + 1) % 256;
    end
    repeat (3) begin
      chk({name, "_idle"}, 32'(observed()), 32'(pack(0, 0, 0, 0, model_fc)));
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, k, fc0, rx, ry, rh, rv, rp;

    vecs[0] = '{4,    2,  2, 3, 0, 18,   "flat_4x2"};
    vecs[1] = '{3,    3,  0, 0, 0, 14,   "zero_blank_3x3"};
    vecs[2] = '{1100, 1,  1, 1, 1, 1103, "ramp_wrap"};
    vecs[3] = '{16,   16, 1, 1, 2, 274,  "checker_16"};
    vecs[4] = '{1300, 1,  1, 2, 1, 1293, "x_clamp"};
    vecs[5] = '{1,    1,  0, 0, 3, 4,    "min_1x1"};
    vecs[6] = '{5,    2,  7, 9, 3, 42,   "count_5x2"};

    bus.start_in          = 1'b0;
    bus.continuous_in     = 1'b0;
    bus.pattern_select_in = 2'd0;
    bus.x_size_in         = 11'd0;
    bus.y_size_in         = 11'd0;
    bus.h_blank_in        = 8'd0;
    bus.v_blank_in        = 8'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'(observed()), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_frames(vecs[i].x, vecs[i].y, vecs[i].h, vecs[i].v, vecs[i].pat, 1, -1, vecs[i].name, len);
      chk({vecs[i].name, "_fv_len"}, 32'(len), 32'(vecs[i].exp_len));
    end

    for (int i = 0; i < 6; i++) begin
      rx = $urandom_range(1, 20);
      ry = $urandom_range(1, 6);
      rh = $urandom_range(0, 5);
      rv = $urandom_range(0, 5);
      rp = $urandom_range(0, 3);
      run_frames(rx, ry, rh, rv, rp, 1, -1, "random", len);
    end

    // start pulse and x_size change mid-frame must not alter or queue anything
    run_frames(6, 3, 2, 2, 1, 1, 9, "midframe_start", len);
    chk("midframe_fv_len", 32'(len), 32'd28);

    bus.x_size_in = 11'd5;
    bus.y_size_in = 11'd0;
    bus.start_in  = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("zero_y_busy", 32'(bus.busy_out), 32'd0);
    tick();
    chk("zero_y_busy2", 32'(bus.busy_out), 32'd0);
    bus.x_size_in = 11'd0;
    bus.y_size_in = 11'd3;
    bus.start_in  = 1'b1;
    tick();
    bus.start_in = 1'b0;
    chk("zero_x_busy", 32'(bus.busy_out), 32'd0);

    // reset in the middle of a line of a 16x16 frame
    bus.x_size_in         = 11'd16;
    bus.y_size_in         = 11'd16;
    bus.h_blank_in        = 8'd1;
    bus.v_blank_in        = 8'd1;
    bus.pattern_select_in = 2'd2;
    bus.start_in          = 1'b1;
    tick();
    bus.start_in = 1'b0;
    k = 0;
    while (bus.line_valid_out !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("reset_wait_line", 32'(k < 50), 32'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("reset_mid_line", 32'(observed()), 32'd0);
    tick();
    rst_n    = 1'b1;
    model_fc = 0;
    tick();
    run_frames(16, 16, 1, 1, 2, 1, -1, "after_reset", len);
    chk("after_reset_fv_len", 32'(len), 32'd274);

    // continuous mode across the 255 -> 0 frame counter wrap
    fc0 = model_fc;
    run_frames(8, 1, 0, 0, 3, 257, -1, "continuous", len);
    chk("continuous_fv_len", 32'(len), 32'd11);
    chk("continuous_fc_wrap", 32'(bus.frame_count_out), 32'((fc0 + 257) % 256));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
